op_amp_sqrt_mc: RTL and testbench

- Multi-channel, parametrised successor to the op-amp square-root loop.
- Computes sqrt of each channel's unsigned integer input with a bit-serial restoring fixed-point root, one bit per clock. Converts each result to IEEE-754 single.
- A clock-enable sample tick replaces the derived divided clock. All channels are sampled on one tick and then processed round-robin.
- Sits between the ADC-side integer sources and the IEEE consumers.

---
 rtl/op_amp_pkg.sv | 18 +
 rtl/fix_to_ieee_norm.sv | 30 +++
 rtl/op_amp_sqrt_mc.sv | 149 ++++++++++++++
 tb/tb_op_amp_sqrt_mc.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/op_amp_pkg.sv
// rtl/op_amp_pkg.sv - shared IEEE constants, root width helper and FSM state type
package op_amp_pkg;

    localparam int          EXP_BIAS   = 127;
    localparam int          MANT_W     = 23;
    localparam logic [31:0] FLOAT_ZERO = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        NORM
    } state_t;

    function automatic int root_width(input int c_width, input int frac_bits);
        return c_width / 2 + frac_bits;
    endfunction

endpackage

// File: rtl/fix_to_ieee_norm.sv
// rtl/fix_to_ieee_norm.sv - unsigned fixed-point root (FRAC_BITS fraction) to IEEE-754 single
module fix_to_ieee_norm
    import op_amp_pkg::*;
#(
    parameter int R         = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic [R-1:0] root,
    output logic [31:0]  ieee
);

    int          msb;
    logic [23:0] ext;
    logic [23:0] shifted;
    logic [7:0]  exp_field;

    always_comb begin
        msb = 0;
        for (int i = 0; i < R; i++) begin
            if (root[i]) msb = i;
        end
        ext       = 24'(root);
        // moving the leading one to bit 23 leaves the mantissa left-aligned below it
        shifted   = ext << (23 - msb);
        exp_field = 8'(EXP_BIAS + msb - FRAC_BITS);
        if (root == '0) ieee = FLOAT_ZERO;
        else            ieee = {1'b0, exp_field, shifted[MANT_W-1:0]};
    end

endmodule

// File: rtl/op_amp_sqrt_mc.sv
// rtl/op_amp_sqrt_mc.sv - multi-channel bit-serial square root with IEEE-754 output
// Optional divided sample clock output: OP_AMP_SAMPLE_CLK_OUT_EN
module op_amp_sqrt_mc
    import op_amp_pkg::*;
#(
    parameter int C_WIDTH   = 16,
    parameter int FRAC_BITS = 8,
    parameter int CH_NUM    = 2,
    parameter int DIV_RATIO = 1000,
    parameter bit CHECK_EN  = 1'b1,
    localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sample_en,
    input  logic [CH_NUM*C_WIDTH-1:0]   non_inv_flat,
    output logic [31:0]                 square_out,
    output logic [CH_W-1:0]             out_ch,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overrun
`ifdef OP_AMP_SAMPLE_CLK_OUT_EN
    ,
    output logic                        sample_clk
`endif
);

    localparam int R     = root_width(C_WIDTH, FRAC_BITS);
    localparam int RAD_W = 2 * R;
    localparam int CNT_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
    localparam int ITR_W = (R > 1) ? $clog2(R) : 1;

    if ((C_WIDTH % 2) != 0 || R > 24) begin : g_width_chk
        $error("op_amp_sqrt_mc: C_WIDTH must be even and C_WIDTH/2+FRAC_BITS <= 24");
    end
    if (CH_NUM < 1) begin : g_ch_chk
        $error("op_amp_sqrt_mc: CH_NUM must be >= 1");
    end
    if (CHECK_EN && DIV_RATIO < CH_NUM * (R + 1) + 1) begin : g_div_chk
        $error("op_amp_sqrt_mc: DIV_RATIO too small for one frame per tick");
    end

    logic [CNT_W-1:0]   cnt;
    logic               tick;
    state_t             state;
    logic [CH_W-1:0]    ch;
    logic [C_WIDTH-1:0] cap_mem [CH_NUM];
    logic [RAD_W-1:0]   rad;
    logic [R+1:0]       rem;
    logic [R-1:0]       root;
    logic [ITR_W-1:0]   itr;
    logic [R+1:0]       rem_sh;
    logic [R+2:0]       trial;
    logic [31:0]        ieee_w;

    assign tick = sample_en && (cnt == CNT_W'(DIV_RATIO - 1));

    always_ff @(posedge clk) begin
        if (!reset_n)       cnt <= '0;
        else if (sample_en) cnt <= tick ? '0 : cnt + 1'b1;
    end

`ifdef OP_AMP_SAMPLE_CLK_OUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            sample_clk <= 1'b0;
        else if (sample_en && (cnt == CNT_W'(DIV_RATIO / 2 - 1) || tick))
            sample_clk <= ~sample_clk;
    end
`endif

    // restoring step: bring down two radicand bits, try subtracting 4*root+1
    always_comb begin
        rem_sh = (rem << 2) | (R + 2)'(rad[RAD_W-1 -: 2]);
        trial  = {1'b0, rem_sh} - {1'b0, root, 2'b01};
    end

    fix_to_ieee_norm #(
        .R         (R),
        .FRAC_BITS (FRAC_BITS)
    ) u_norm (
        .root (root),
        .ieee (ieee_w)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ch         <= '0;
            rad        <= '0;
            rem        <= '0;
            root       <= '0;
            itr        <= '0;
            square_out <= FLOAT_ZERO;
            out_ch     <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) cap_mem[i] <= '0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        for (int i = 0; i < CH_NUM; i++)
                            cap_mem[i] <= non_inv_flat[i*C_WIDTH +: C_WIDTH];
                        rad   <= RAD_W'(non_inv_flat[C_WIDTH-1:0]) << (2 * FRAC_BITS);
                        rem   <= '0;
                        root  <= '0;
                        itr   <= '0;
                        ch    <= '0;
                        busy  <= 1'b1;
                        state <= ITER;
                    end
                end
                ITER: begin
                    rad  <= rad << 2;
                    rem  <= trial[R+2] ? rem_sh : trial[R+1:0];
                    root <= {root[R-2:0], ~trial[R+2]};
                    itr  <= itr + 1'b1;
                    if (itr == ITR_W'(R - 1)) state <= NORM;
                end
                NORM: begin
                    square_out <= ieee_w;
                    out_ch     <= ch;
                    out_valid  <= 1'b1;
                    if (ch == CH_W'(CH_NUM - 1)) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        ch    <= ch + 1'b1;
                        rad   <= RAD_W'(cap_mem[ch + 1'b1]) << (2 * FRAC_BITS);
                        rem   <= '0;
                        root  <= '0;
                        itr   <= '0;
                        state <= ITER;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_amp_sqrt_mc.sv
// tb/tb_op_amp_sqrt_mc.sv - directed and random checks of op_amp_sqrt_mc against a float model
module tb_op_amp_sqrt_mc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_en;
    logic [31:0] flat0;
    logic [31:0] flat1;
    logic [31:0] sq0, sq1;
    logic        oc0, oc1;
    logic        ov0, ov1, bz0, bz1, fd0, fd1, or0, or1;
`ifdef OP_AMP_SAMPLE_CLK_OUT_EN
    logic        sc0, sc1;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    op_amp_sqrt_mc #(.C_WIDTH(16), .FRAC_BITS(8), .CH_NUM(2), .DIV_RATIO(40)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_en    (sample_en),
        .non_inv_flat (flat0),
        .square_out   (sq0),
        .out_ch       (oc0),
        .out_valid    (ov0),
        .busy         (bz0),
        .frame_done   (fd0),
        .overrun      (or0)
`ifdef OP_AMP_SAMPLE_CLK_OUT_EN
        ,
        .sample_clk   (sc0)
`endif
    );

    op_amp_sqrt_mc #(.C_WIDTH(16), .FRAC_BITS(8), .CH_NUM(2), .DIV_RATIO(20), .CHECK_EN(1'b0)) dut_ovr (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_en    (1'b1),
        .non_inv_flat (flat1),
        .square_out   (sq1),
        .out_ch       (oc1),
        .out_valid    (ov1),
        .busy         (bz1),
        .frame_done   (fd1),
        .overrun      (or1)
`ifdef OP_AMP_SAMPLE_CLK_OUT_EN
        ,
        .sample_clk   (sc1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint isqrt(input longint v);
        longint r = longint'($sqrt(real'(v)));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // sqrt(x) in Q.8, then rounded through a double and repacked as a single
    function automatic logic [31:0] ref_float(input logic [15:0] x);
        longint      r = isqrt(longint'(x) << 16);
        logic [63:0] d;
        if (r == 0) return 32'h0;
        d = $realtobits(real'(r) / 256.0);
        return {1'b0, 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    task automatic frame_check(input logic [15:0] a, input logic [15:0] b,
                               input logic [31:0] e0, input logic [31:0] e1,
                               output int waited);
        int stray = 0;
        flat0  = {b, a};
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!bz0 && waited < 200);
        chk("tick_busy", bz0, 1);
        flat0 = $urandom;
        for (int j = 1; j <= 34; j++) begin
            @(posedge clk); #1;
            if (j == 17) begin
                chk("c0_valid", ov0, 1);
                chk("c0_data", sq0, e0);
                chk("c0_ch", oc0, 0);
                chk("c0_fd", fd0, 0);
                chk("c0_busy", bz0, 1);
            end else if (j == 34) begin
                chk("c1_valid", ov0, 1);
                chk("c1_data", sq0, e1);
                chk("c1_ch", oc0, 1);
                chk("c1_fd", fd0, 1);
                chk("c1_busy", bz0, 0);
            end else if (ov0) begin
                stray++;
            end
        end
        chk("stray_valid", stray, 0);
    endtask

    initial begin
        int st0 = 0;
        int st1 = 0;
        int w;
        int cnt;
        logic [15:0] ra, rb;

        reset_n   = 1'b0;
        sample_en = 1'b1;
        flat0     = {16'd100, 16'd36};
        flat1     = {16'd100, 16'd36};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_square", sq0, 0);
        chk("rst_ch", oc0, 0);
        chk("rst_valid", ov0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_fd", fd0, 0);
        chk("rst_ovr", or0, 0);
        reset_n = 1'b1;

        for (int n = 1; n <= 79; n++) begin
            @(posedge clk); #1;
            if (n == 57) begin
                chk("f0_c0_valid", ov0, 1);
                chk("f0_c0_data", sq0, 32'h40C00000);
                chk("f0_c0_ch", oc0, 0);
                chk("f0_c0_fd", fd0, 0);
            end else if (n == 74) begin
                chk("f0_c1_valid", ov0, 1);
                chk("f0_c1_data", sq0, 32'h41200000);
                chk("f0_c1_ch", oc0, 1);
                chk("f0_c1_fd", fd0, 1);
                chk("f0_busy_end", bz0, 0);
            end else if (ov0) begin
                st0++;
            end
            if (n == 39) chk("f0_busy_pre", bz0, 0);
            if (n == 40) chk("f0_busy_tick", bz0, 1);
            if (n == 37 || n == 54 || n == 77) begin
                chk("ovr_valid", ov1, 1);
                chk("ovr_data", sq1, (n == 54) ? ref_float(16'd100) : ref_float(16'd36));
            end else if (ov1) begin
                st1++;
            end
            if (n == 39) chk("ovr_before", or1, 0);
            if (n == 40) chk("ovr_set", or1, 1);
            if (n == 79) chk("ovr_sticky", or1, 1);
        end
        chk("f0_stray", st0, 0);
        chk("ovr_stray", st1, 0);
        chk("main_no_ovr", or0, 0);

        frame_check(16'd0, 16'd65535, 32'h00000000, 32'h437FFF00, w);
        chk("tick_period", w, 1);
        frame_check(16'd2, 16'd1, 32'h3FB50000, 32'h3F800000, w);

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            frame_check(ra, rb, ref_float(ra), ref_float(rb), w);
        end

        // reset one cycle, ten edges into a frame
        flat0 = {16'd100, 16'd36};
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!bz0 && cnt < 200);
        chk("rst_mid_start", bz0, 1);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_square", sq0, 0);
        chk("rst_mid_ch", oc0, 0);
        chk("rst_mid_valid", ov0, 0);
        chk("rst_mid_busy", bz0, 0);
        chk("rst_mid_fd", fd0, 0);
        chk("rst_mid_ovr1", or1, 0);
        reset_n = 1'b1;
        cnt = 0;
        for (int n = 1; n <= 39; n++) begin
            @(posedge clk); #1;
            if (ov0 || bz0) cnt++;
        end
        chk("rst_mid_quiet", cnt, 0);
        frame_check(16'd36, 16'd100, 32'h40C00000, 32'h41200000, w);
        chk("rst_mid_restart", w, 1);

        // pause the divider between frames
        sample_en = 1'b0;
        cnt = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (ov0 || bz0) cnt++;
        end
        chk("pause_quiet", cnt, 0);
        chk("pause_hold", sq0, 32'h41200000);
        sample_en = 1'b1;
        ra = 16'($urandom);
        rb = 16'($urandom);
        frame_check(ra, rb, ref_float(ra), ref_float(rb), w);
        chk("resume_wait", w, 6);

`ifdef OP_AMP_SAMPLE_CLK_OUT_EN
        begin : sclk_meas
            int   r1 = -1;
            int   r2 = -1;
            int   f1 = -1;
            int   tg = 0;
            logic prev;
            sample_en = 1'b0;
            prev = sc0;
            for (int n = 1; n <= 50; n++) begin
                @(posedge clk); #1;
                if (sc0 !== prev) tg++;
                prev = sc0;
            end
            chk("sclk_pause_hold", tg, 0);
            sample_en = 1'b1;
            for (int n = 1; n <= 100; n++) begin
                @(posedge clk); #1;
                if (!prev && sc0) begin
                    if (r1 < 0) r1 = n;
                    else if (r2 < 0) r2 = n;
                end
                if (prev && !sc0 && r1 >= 0 && f1 < 0) f1 = n;
                prev = sc0;
            end
            chk("sclk_high", f1 - r1, 20);
            chk("sclk_period", r2 - r1, 40);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
